pixel_plotter: RTL and testbench
================================

Name: pixel_plotter

Overview:
- Consumer end of the line-drawing pixel stream. Accepts X/Y coordinates emitted by the line generator and buffers them in a small FIFO.
- Clips any coordinate outside the framebuffer, converts the rest to linear framebuffer addresses, and issues single-word writes to video memory over a request/acknowledge handshake.
- Reports line completion back to the controller once every pixel of the line has been written or dropped.

Parameters:
- FB_WIDTH, 160, framebuffer width in pixels.
- FB_HEIGHT, 120, framebuffer height in pixels.
- ADDR_W, 15, memory address width.
- COLOR_W, 8, pixel colour width.
- FIFO_DEPTH, 4, pixel FIFO entries; must be a power of 2, minimum 2.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- X_In  in  8  pixel X coordinate.
- Y_In  in  8  pixel Y coordinate.
- COLOR  in  COLOR_W  pixel colour, captured together with X_In/Y_In.
- PIX_VALID  in  1  X_In/Y_In/COLOR valid.
- PIX_READY  out  1  FIFO can accept a pixel.
- LINE_FINISH  in  1  level from the line generator; high when the line is complete.
- MEM_ADDR  out  ADDR_W  write address.
- MEM_DATA  out  COLOR_W  write data.
- MEM_WE  out  1  write request.
- MEM_ACK  in  1  memory accepted the write.
- DONE  out  1  one-cycle pulse when the line is fully plotted.
- CLIP_CNT  out  8  saturating count of dropped pixels since reset.

Behaviour:
Clock and reset:
- One clock, ACLK. RST is synchronous, active-high.
- Reset values: PIX_READY=1, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, DONE=0, CLIP_CNT=0. FIFO is empty, state is IDLE, finish_pending=0.

FIFO:
- A push occurs when PIX_VALID && PIX_READY; the entry is {X_In, Y_In, COLOR}.
- PIX_READY = !full, driven combinationally from the FIFO count.
- A push and a pop may happen in the same cycle; the count is then unchanged.
- When full, PIX_READY=0 and PIX_VALID is ignored.
- Read and write pointers wrap modulo FIFO_DEPTH.

State machine (IDLE, ADDR, WRITE):
- IDLE, FIFO non-empty:
  - Pop the head entry.
  - If X>=FB_WIDTH or Y>=FB_HEIGHT: drop the pixel, CLIP_CNT+=1 (saturates at 255), stay in IDLE.
  - Otherwise: latch X, Y and colour, go to ADDR.
- ADDR: MEM_ADDR <= Y*FB_WIDTH + X, computed at full width and truncated to ADDR_W. MEM_DATA <= colour. MEM_WE <= 1. Go to WRITE.
- WRITE: hold MEM_WE, MEM_ADDR and MEM_DATA stable until MEM_ACK is sampled high. On that edge MEM_WE <= 0 and the state returns to IDLE.
- An ACK that is already high on the first WRITE cycle completes the write in that cycle.

Timing:
- Latency: a pixel accepted at edge t with the FIFO empty and the state IDLE is popped at t+1. MEM_WE is high after edge t+2.
- Best-case throughput: one pixel per 3 cycles.
- MEM_ACK seen while MEM_WE=0 is ignored.

Completion:
- A rising edge of LINE_FINISH (registered previous value 0, current value 1) sets finish_pending.
- DONE pulses for exactly one cycle when finish_pending=1, the FIFO is empty, the state is IDLE and no push occurs that cycle. finish_pending clears on the same edge.
- If LINE_FINISH rises while pixels are still queued, DONE waits until they drain.
- A second rising edge while finish_pending=1 is absorbed and produces a single DONE.

Reset mid-operation:
- RST during WRITE drops MEM_WE on the next edge.
- The FIFO is flushed, pending finish is cleared, and the aborted write is not retried.

Test Plan:
- Reset, then push (X=3, Y=2, COLOR=0x5A) with MEM_ACK tied high → MEM_WE high for 1 cycle starting 2 cycles after accept, MEM_ADDR=323, MEM_DATA=0x5A.
- Push 6 pixels back-to-back with MEM_ACK held low → PIX_READY falls after 5 accepts (4 queued + 1 popped), and MEM_WE/MEM_ADDR stay stable. Release ACK → all 6 addresses are written in push order.
- Push (160,0), (0,120), (159,119) → the first two are dropped with CLIP_CNT=2 and no MEM_WE; the third writes MEM_ADDR=19199.
- Push 3 pixels then raise LINE_FINISH while the first write is stalled → DONE is a single pulse one cycle after the third ACK returns the state to IDLE. Holding LINE_FINISH high produces no further DONE.
- Push 300 out-of-range pixels → CLIP_CNT saturates at 255 and never wraps.
- Assert RST for 1 cycle during WRITE with 2 entries queued → MEM_WE=0, PIX_READY=1 and CLIP_CNT=0 on the next cycle, and no further writes or DONE are issued.

Source files
------------

// File: rtl/pixel_plotter_if.sv
// pixel_plotter_if: bundles the pixel stream coming from the line generator,
// the video-memory write handshake and the status outputs of the plotter.
//   slave  modport: the plotter (consumes pixels, masters memory writes)
//   master modport: the line generator / memory / controller side
//   X_In, Y_In, COLOR, PIX_VALID, PIX_READY : pixel stream with ready/valid
//   LINE_FINISH                              : line generator completion level
//   MEM_ADDR, MEM_DATA, MEM_WE, MEM_ACK      : single-word write request/ack
//   DONE, CLIP_CNT                           : completion pulse, dropped pixels
interface pixel_plotter_if #(
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 8
);
  logic [7:0]         X_In;
  logic [7:0]         Y_In;
  logic [COLOR_W-1:0] COLOR;
  logic               PIX_VALID;
  logic               PIX_READY;
  logic               LINE_FINISH;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic [COLOR_W-1:0] MEM_DATA;
  logic               MEM_WE;
  logic               MEM_ACK;
  logic               DONE;
  logic [7:0]         CLIP_CNT;

  modport slave (
    input  X_In, Y_In, COLOR, PIX_VALID, LINE_FINISH, MEM_ACK,
    output PIX_READY, MEM_ADDR, MEM_DATA, MEM_WE, DONE, CLIP_CNT
  );

  modport master (
    output X_In, Y_In, COLOR, PIX_VALID, LINE_FINISH, MEM_ACK,
    input  PIX_READY, MEM_ADDR, MEM_DATA, MEM_WE, DONE, CLIP_CNT
  );
endinterface

// File: rtl/pixel_plotter.sv
// pixel_plotter: buffers incoming pixels in a small FIFO, drops pixels that
// fall outside the framebuffer (counting them), turns the rest into linear
// addresses and writes them one at a time over a request/acknowledge
// handshake. DONE pulses once the line generator has finished and every
// queued pixel has been written or dropped.
//   ACLK : clock, rising edge
//   RST  : synchronous reset, active-high
//   bus  : pixel_plotter_if.slave (pixel stream, memory port, status)
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a FIFO entry; pops it and clips or accepts it
// S_ADDR  | forms the linear address and raises the write request
// S_WRITE | holds the request stable until MEM_ACK is seen
module pixel_plotter #(
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 120,
  parameter int ADDR_W     = 15,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            ACLK,
  input  logic            RST,
  pixel_plotter_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 16 + COLOR_W;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WRITE} state_t;

  state_t             r_state;
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_x;
  logic [7:0]         r_y;
  logic [COLOR_W-1:0] r_col;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [COLOR_W-1:0] r_mem_data;
  logic               r_we;
  logic               r_done;
  logic [7:0]         r_clip_cnt;
  logic               r_lf_prev;
  logic               r_fin_pend;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [ENT_W-1:0]   w_head;
  logic [7:0]         w_head_x;
  logic [7:0]         w_head_y;
  logic [COLOR_W-1:0] w_head_col;
  logic               w_clip;
  logic               w_lf_rise;
  logic               w_done_cond;
  logic [ADDR_W-1:0]  w_addr;

  always_comb begin
    w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    w_empty     = (r_count == '0);
    w_push      = bus.PIX_VALID && !w_full;
    w_pop       = (r_state == S_IDLE) && !w_empty;
    w_head      = r_mem[r_rptr];
    w_head_x    = w_head[ENT_W-1 -: 8];
    w_head_y    = w_head[ENT_W-9 -: 8];
    w_head_col  = w_head[COLOR_W-1:0];
    w_clip      = (32'(w_head_x) >= 32'(FB_WIDTH)) || (32'(w_head_y) >= 32'(FB_HEIGHT));
    w_lf_rise   = bus.LINE_FINISH && !r_lf_prev;
    // A push in the same cycle means more work is arriving, so hold DONE off.
    w_done_cond = r_fin_pend && w_empty && (r_state == S_IDLE) && !w_push;
    // Full-width product, then truncated to the memory address width.
    w_addr      = ADDR_W'(32'(r_y) * 32'(FB_WIDTH) + 32'(r_x));
  end

  assign bus.PIX_READY = !w_full;
  assign bus.MEM_ADDR  = r_mem_addr;
  assign bus.MEM_DATA  = r_mem_data;
  assign bus.MEM_WE    = r_we;
  assign bus.DONE      = r_done;
  assign bus.CLIP_CNT  = r_clip_cnt;

  // Storage needs no reset: only entries counted by r_count are ever read.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.X_In, bus.Y_In, bus.COLOR};
    end
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_col      <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_clip_cnt <= '0;
      r_lf_prev  <= 1'b0;
      r_fin_pend <= 1'b0;
    end else begin
      r_lf_prev <= bus.LINE_FINISH;
      r_done    <= w_done_cond;

      // Clearing wins over a coincident rise so one line yields one DONE.
      if (w_done_cond) begin
        r_fin_pend <= 1'b0;
      end else if (w_lf_rise) begin
        r_fin_pend <= 1'b1;
      end

      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_clip) begin
              if (r_clip_cnt != 8'hFF) begin
                r_clip_cnt <= r_clip_cnt + 8'd1;
              end
            end else begin
              r_x     <= w_head_x;
              r_y     <= w_head_y;
              r_col   <= w_head_col;
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          r_mem_addr <= w_addr;
          r_mem_data <= r_col;
          r_we       <= 1'b1;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          if (bus.MEM_ACK) begin
            r_we    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_plotter.sv
module tb_pixel_plotter;
  localparam int FBW = 160;
  localparam int FBH = 120;

  logic ACLK = 1'b0;
  logic RST  = 1'b1;
  always #5 ACLK = ~ACLK;

  pixel_plotter_if bus ();

  pixel_plotter dut (
    .ACLK (ACLK),
    .RST  (RST),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: queue of expected writes in push order + clip count
  int exp_a[$];
  int exp_d[$];
  int clip_m = 0;

  // observed writes, collected by the monitor
  int obs_a[$];
  int obs_d[$];
  int cyc = 0;
  int wr_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int stab_err = 0;
  int wrap_err = 0;
  int last_wait = 0;

  logic ack_rand = 1'b0;
  logic ack_level = 1'b0;
  logic ack_rnd_val = 1'b0;
  assign bus.MEM_ACK = ack_rand ? ack_rnd_val : ack_level;
  always @(negedge ACLK) ack_rnd_val <= 1'($urandom_range(0, 1));

  logic        p_we = 1'b0;
  logic        p_ack = 1'b0;
  logic [14:0] p_addr = '0;
  logic [7:0]  p_data = '0;
  logic [7:0]  p_clip = '0;

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (RST) begin
      p_we   <= 1'b0;
      p_clip <= '0;
    end else begin
      if (bus.MEM_WE && bus.MEM_ACK) begin
        obs_a.push_back(int'(bus.MEM_ADDR));
        obs_d.push_back(int'(bus.MEM_DATA));
        wr_cyc <= cyc;
      end
      if (bus.DONE) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (p_we && !p_ack &&
          (!bus.MEM_WE || bus.MEM_ADDR !== p_addr || bus.MEM_DATA !== p_data))
        stab_err <= stab_err + 1;
      if (bus.CLIP_CNT < p_clip) wrap_err <= wrap_err + 1;
      p_we   <= bus.MEM_WE;
      p_ack  <= bus.MEM_ACK;
      p_addr <= bus.MEM_ADDR;
      p_data <= bus.MEM_DATA;
      p_clip <= bus.CLIP_CNT;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_pix(input int x, input int y, input int c);
    int w = 0;
    @(negedge ACLK);
    bus.X_In      = 8'(x);
    bus.Y_In      = 8'(y);
    bus.COLOR     = 8'(c);
    bus.PIX_VALID = 1'b1;
    while (!bus.PIX_READY && w < 300) begin
      @(negedge ACLK);
      w++;
    end
    last_wait = w;
    if (w >= 300) chk("push_timeout", w, 0);
    @(posedge ACLK);
    #1 bus.PIX_VALID = 1'b0;
    if (x >= FBW || y >= FBH) begin
      if (clip_m < 255) clip_m++;
    end else begin
      exp_a.push_back(y * FBW + x);
      exp_d.push_back(c);
    end
  endtask

  task automatic drain_check(input string tag);
    int w = 0;
    while (obs_a.size() < exp_a.size() && w < 1000) begin
      @(negedge ACLK);
      w++;
    end
    repeat (6) @(negedge ACLK);
    chk({tag, "_nwr"}, obs_a.size(), exp_a.size());
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      chk({tag, "_addr"}, obs_a.pop_front(), exp_a.pop_front());
      chk({tag, "_data"}, obs_d.pop_front(), exp_d.pop_front());
    end
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    chk({tag, "_clip"}, int'(bus.CLIP_CNT), clip_m);
  endtask

  initial begin
    int sum_wait;
    int d0;
    bus.X_In = '0; bus.Y_In = '0; bus.COLOR = '0;
    bus.PIX_VALID = 1'b0; bus.LINE_FINISH = 1'b0;

    // reset values
    repeat (3) @(negedge ACLK);
    chk("rst_ready", int'(bus.PIX_READY), 1);
    chk("rst_we",    int'(bus.MEM_WE), 0);
    chk("rst_addr",  int'(bus.MEM_ADDR), 0);
    chk("rst_data",  int'(bus.MEM_DATA), 0);
    chk("rst_done",  int'(bus.DONE), 0);
    chk("rst_clip",  int'(bus.CLIP_CNT), 0);
    RST = 1'b0;
    repeat (2) @(negedge ACLK);

    // single pixel, ACK tied high: latency and address
    ack_level = 1'b1;
    push_pix(3, 2, 8'h5A);
    @(negedge ACLK);
    chk("lat_we_t0", int'(bus.MEM_WE), 0);
    @(negedge ACLK);
    chk("lat_we_t1", int'(bus.MEM_WE), 0);
    @(negedge ACLK);
    chk("lat_we_t2", int'(bus.MEM_WE), 1);
    chk("lat_addr",  int'(bus.MEM_ADDR), 323);
    chk("lat_data",  int'(bus.MEM_DATA), 8'h5A);
    @(negedge ACLK);
    chk("lat_we_t3", int'(bus.MEM_WE), 0);
    drain_check("single");

    // six pixels with ACK low: back-pressure after 5 accepts
    ack_level = 1'b0;
    sum_wait = 0;
    for (int i = 0; i < 5; i++) begin
      push_pix($urandom_range(0, FBW - 1), $urandom_range(0, FBH - 1), $urandom_range(0, 255));
      sum_wait += last_wait;
    end
    chk("bp_b2b", sum_wait, 0);
    @(negedge ACLK);
    chk("bp_ready", int'(bus.PIX_READY), 0);
    chk("bp_we", int'(bus.MEM_WE), 1);
    chk("bp_addr0", int'(bus.MEM_ADDR), exp_a[0]);
    repeat (5) @(negedge ACLK);
    chk("bp_we_hold", int'(bus.MEM_WE), 1);
    chk("bp_addr_hold", int'(bus.MEM_ADDR), exp_a[0]);
    chk("bp_data_hold", int'(bus.MEM_DATA), exp_d[0]);
    ack_level = 1'b1;
    push_pix($urandom_range(0, FBW - 1), $urandom_range(0, FBH - 1), $urandom_range(0, 255));
    drain_check("bp");

    // clipping boundaries
    push_pix(160, 0, 8'h11);
    push_pix(0, 120, 8'h22);
    push_pix(159, 119, 8'h33);
    repeat (6) @(negedge ACLK);
    chk("clip_cnt2", int'(bus.CLIP_CNT), 2);
    chk("clip_last_addr", obs_a.size() > 0 ? obs_a[obs_a.size() - 1] : -1, 19199);
    drain_check("clip");

    // randomized mix with random ACK
    ack_rand = 1'b1;
    for (int i = 0; i < 24; i++)
      push_pix($urandom_range(0, 199), $urandom_range(0, 149), $urandom_range(0, 255));
    ack_rand = 1'b0;
    ack_level = 1'b1;
    drain_check("rand");

    // completion: double rise during stall, single DONE after drain
    chk("no_done_yet", done_cnt, 0);
    d0 = done_cnt;
    ack_level = 1'b0;
    for (int i = 0; i < 3; i++)
      push_pix($urandom_range(0, FBW - 1), $urandom_range(0, FBH - 1), $urandom_range(0, 255));
    repeat (3) @(negedge ACLK);
    chk("line_stall_we", int'(bus.MEM_WE), 1);
    bus.LINE_FINISH = 1'b1;
    repeat (2) @(negedge ACLK);
    bus.LINE_FINISH = 1'b0;
    repeat (2) @(negedge ACLK);
    bus.LINE_FINISH = 1'b1;
    repeat (5) @(negedge ACLK);
    chk("line_wait_done", done_cnt, d0);
    ack_level = 1'b1;
    drain_check("line");
    repeat (20) @(negedge ACLK);
    chk("line_one_done", done_cnt, d0 + 1);
    chk("line_done_time", done_cyc - wr_cyc, 2);
    bus.LINE_FINISH = 1'b0;
    repeat (3) @(negedge ACLK);

    // saturation of the clip counter
    for (int i = 0; i < 300; i++)
      push_pix($urandom_range(FBW, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (4) @(negedge ACLK);
    chk("sat_clip", int'(bus.CLIP_CNT), clip_m);
    chk("sat_255", int'(bus.CLIP_CNT), 255);
    chk("sat_no_wr", obs_a.size(), 0);
    chk("sat_nowrap", wrap_err, 0);

    // reset during WRITE with two entries queued
    ack_level = 1'b0;
    for (int i = 0; i < 3; i++)
      push_pix($urandom_range(0, FBW - 1), $urandom_range(0, FBH - 1), $urandom_range(0, 255));
    repeat (2) @(negedge ACLK);
    chk("mid_we", int'(bus.MEM_WE), 1);
    chk("mid_ready", int'(bus.PIX_READY), 1);
    RST = 1'b1;
    @(negedge ACLK);
    RST = 1'b0;
    exp_a.delete(); exp_d.delete(); clip_m = 0;
    chk("mrst_we", int'(bus.MEM_WE), 0);
    chk("mrst_ready", int'(bus.PIX_READY), 1);
    chk("mrst_clip", int'(bus.CLIP_CNT), 0);
    d0 = done_cnt;
    ack_level = 1'b1;
    repeat (30) @(negedge ACLK);
    chk("mrst_no_wr", obs_a.size(), 0);
    chk("mrst_no_done", done_cnt, d0);
    chk("mrst_we_low", int'(bus.MEM_WE), 0);

    chk("stable_hold", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
